debounce_fsm: RTL and testbench

Mechanical-switch conditioning stage placed directly upstream of the edge detectors. It synchronises a raw asynchronous input, then uses a four-state FSM with a down-counter to debounce it. A level change is accepted only after the input has held the new value for DB_CYCLES consecutive clocks. The block outputs the clean level, plus a one-cycle tick when a rising level is accepted.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_fsm_sync_2ff.sv | 22 ++
 rtl/debounce_fsm.sv | 102 ++++++++++
 tb/tb_debounce_fsm.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the switch-debounce stage.
// The FSM state encoding is fixed here so the other input stages can decode it.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/debounce_fsm_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Only q may be used downstream; the first flop is allowed to go metastable.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s_meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      s_meta <= d;
      q      <= s_meta;
    end
  end

endmodule

// File: rtl/debounce_fsm.sv
// Debounces a raw switch: a new level is accepted only after it has held for
// DB_CYCLES consecutive clocks; a one-cycle tick marks each accepted rise.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sw,
  output logic o_level,
  output logic o_tick
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  db_state_t        state;
  db_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_reg;
  logic             tick_next;
  logic             s_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_sw),
    .q     (s_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ZERO;
      cnt      <= CNT_ZERO;
      tick_reg <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      tick_reg <= tick_next;
    end
  end

  // The s_sync test comes first in each WAIT state so a bounce on the
  // expiry cycle rejects the change instead of accepting it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (s_sync) begin
          state_next = WAIT1;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!s_sync) begin
          state_next = ZERO;
        end else if (cnt == CNT_ZERO) begin
          state_next = ONE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ONE: begin
        if (!s_sync) begin
          state_next = WAIT0;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (s_sync) begin
          state_next = ONE;
        end else if (cnt == CNT_ZERO) begin
          state_next = ZERO;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = ZERO;
      end
    endcase
  end

  always_comb begin
    tick_next = (state == WAIT1) && (state_next == ONE);
  end

  always_comb begin
    o_level = 1'b0;
    case (state)
      ONE, WAIT0: o_level = 1'b1;
      default:    o_level = 1'b0;
    endcase
  end

  assign o_tick = tick_reg;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with DB_CYCLES=4 and DB_CYCLES=1 instances.
// Outputs are sampled 1 time unit after each rising edge.
module tb_debounce_fsm;
  import debounce_pkg::*;

  logic clk;
  logic reset;
  logic sw4;
  logic sw1;
  logic level4;
  logic tick4;
  logic level1;
  logic tick1;

  int n_checks;
  int n_fail;
  int tick_count;

  localparam logic [3:0] BOUNCE_PAT = 4'b0000;

  debounce_fsm #(.DB_CYCLES(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .i_sw    (sw4),
    .o_level (level4),
    .o_tick  (tick4)
  );

  debounce_fsm #(.DB_CYCLES(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .i_sw    (sw1),
    .o_level (level1),
    .o_tick  (tick1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v4, input logic v1);
    sw4 = v4;
    sw1 = v1;
  endtask

  initial begin
    logic [6:0] pat;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    apply_stimulus(1'b1, 1'b0);

    // Reset held low with the switch high: nothing may move.
    for (int i = 0; i < 5; i++) begin
      step();
      check_output("rst_hold_level", 32'(level4), 32'd0);
      check_output("rst_hold_tick", 32'(tick4), 32'd0);
    end
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_output($sformatf("rise_level_e%0d", i), 32'(level4), (i >= 7) ? 32'd1 : 32'd0);
      check_output($sformatf("rise_tick_e%0d", i), 32'(tick4), (i == 7) ? 32'd1 : 32'd0);
    end

    // Clean release: falls after the 7th edge with no tick.
    apply_stimulus(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check_output($sformatf("fall_level_e%0d", i), 32'(level4), (i >= 7) ? 32'd0 : 32'd1);
      check_output($sformatf("fall_tick_e%0d", i), 32'(tick4), 32'd0);
    end

    // Three-cycle glitch is shorter than the window.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus((i < 3) ? 1'b1 : 1'b0, 1'b0);
      step();
      check_output("glitch3_level", 32'(level4), 32'd0);
      check_output("glitch3_tick", 32'(tick4), 32'd0);
    end

    // Bounce pattern 1,1,0,1,1,1,0 then low.
    pat = 7'b0111011;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus((i < 7) ? pat[i] : 1'b0, 1'b0);
      step();
      check_output("bounce_level", 32'(level4), 32'd0);
      check_output("bounce_tick", 32'(tick4), 32'd0);
    end

    // Input drops exactly on the cycle where cnt reaches 0 in WAIT1.
    for (int i = 1; i <= 7; i++) begin
      apply_stimulus((i <= 4) ? 1'b1 : 1'b0, 1'b0);
      step();
      if (i == 6) begin
        check_output("expiry_state_wait1", 32'(dut4.state), 32'(WAIT1));
        check_output("expiry_cnt_zero", 32'(dut4.cnt), 32'd0);
      end
    end
    check_output("expiry_state_zero", 32'(dut4.state), 32'(ZERO));
    check_output("expiry_tick", 32'(tick4), 32'd0);
    check_output("expiry_level", 32'(level4), 32'd0);
    apply_stimulus(1'b0, 1'b0);
    repeat (4) step();

    // DB_CYCLES=1: accepted after edge 4 counted from the first sampling edge.
    apply_stimulus(1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check_output($sformatf("db1_level_e%0d", i), 32'(level1), (i >= 4) ? 32'd1 : 32'd0);
      check_output($sformatf("db1_tick_e%0d", i), 32'(tick1), (i == 4) ? 32'd1 : 32'd0);
    end
    apply_stimulus(1'b0, 1'b0);
    repeat (6) step();
    check_output("db1_fall_level", 32'(level1), 32'd0);

    tick_count = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, (i < 1) ? 1'b1 : 1'b0);
      step();
      if (tick1) tick_count++;
      check_output("db1_glitch1_level", 32'(level1), 32'd0);
    end
    check_output("db1_glitch1_ticks", 32'(tick_count), 32'd0);

    tick_count = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b0, (i < 2) ? 1'b1 : 1'b0);
      step();
      if (tick1) tick_count++;
    end
    check_output("db1_pulse2_ticks", 32'(tick_count), 32'd1);
    check_output("db1_pulse2_end_level", 32'(level1), 32'd0);

    // Asynchronous reset between edges while in WAIT1 with cnt=2.
    apply_stimulus(1'b1, 1'b0);
    repeat (4) step();
    check_output("mid_wait1_state", 32'(dut4.state), 32'(WAIT1));
    check_output("mid_wait1_cnt", 32'(dut4.cnt), 32'd2);
    #3;
    reset = 1'b0;
    #1;
    check_output("arst_state", 32'(dut4.state), 32'(ZERO));
    check_output("arst_cnt", 32'(dut4.cnt), 32'd0);
    check_output("arst_sync", 32'(dut4.s_sync), 32'd0);
    check_output("arst_level", 32'(level4), 32'd0);
    check_output("arst_tick", 32'(tick4), 32'd0);
    #2;
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_output($sformatf("rerise_level_e%0d", i), 32'(level4), (i >= 7) ? 32'd1 : 32'd0);
      check_output($sformatf("rerise_tick_e%0d", i), 32'(tick4), (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset mid-pulse must kill the tick immediately.
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_tick_midpulse", 32'(tick4), 32'd0);
    check_output("arst_level_midpulse", 32'(level4), 32'd0);
    #2;
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
